mcpu_control_fsm: RTL and testbench

Multi-cycle control state machine for the single-memory MIPS-subset CPU. Sits directly upstream of the datapath: it consumes the opcode/funct fields latched in the IR, the ALU zero flag and a memory-ready strobe, and drives every register write-enable, mux select and ALU command the datapath needs. One instruction executes as a 3–5 state sequence, with memory states stretched by `mem_ready`.

---
 rtl/mcpu_pkg.sv | 110 +++++++++++
 rtl/mcpu_control_fsm_if.sv | 39 +++
 rtl/mcpu_ctrl_decode.sv | 120 ++++++++++++
 rtl/mcpu_control_fsm.sv | 71 +++++++
 tb/tb_mcpu_control_fsm.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset control path.
// Holds the state encoding, opcode/funct constants, ALU and mux select codes, the
// control-word struct produced by the decoder and a dispatch helper used in DECODE.
package mcpu_pkg;

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StExecR   = 4'd2,
    StWbR     = 4'd3,
    StExecI   = 4'd4,
    StWbI     = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StMemWb   = 4'd8,
    StMemWr   = 4'd9,
    StBranch  = 4'd10,
    StJump    = 4'd11,
    StJal     = 4'd12,
    StJr      = 4'd13
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FnJr  = 6'h08;
  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnSlt = 6'h2A;

  // ALU commands
  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluSub  = 3'd1;
  localparam logic [2:0] AluXor  = 3'd2;
  localparam logic [2:0] AluSlt  = 3'd3;
  localparam logic [2:0] AluAnd  = 3'd4;
  localparam logic [2:0] AluNand = 3'd5;
  localparam logic [2:0] AluNor  = 3'd6;
  localparam logic [2:0] AluOr   = 3'd7;

  // ALU operand A select
  localparam logic [1:0] SrcAPc   = 2'd0;
  localparam logic [1:0] SrcAReg  = 2'd1;
  localparam logic [1:0] SrcABen  = 2'd2;
  localparam logic [1:0] SrcAZero = 2'd3;

  // ALU operand B select
  localparam logic [1:0] SrcBImmSh = 2'd0;
  localparam logic [1:0] SrcBImm   = 2'd1;
  localparam logic [1:0] SrcBReg   = 2'd2;
  localparam logic [1:0] SrcBFour  = 2'd3;

  // Next-PC select
  localparam logic [1:0] PcBen  = 2'd0;
  localparam logic [1:0] PcJump = 2'd1;
  localparam logic [1:0] PcAlu  = 2'd2;
  localparam logic [1:0] PcA    = 2'd3;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       a_we;
    logic       b_we;
    logic       ben;
    logic       mem_we;
    logic       reg_we;
    logic       memin;
    logic       dst;
    logic       regin;
    logic       jal;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic       retire;
    logic       illegal;
  } ctrl_t;

  // First execute state for an instruction; StFetch marks an unsupported encoding.
  function automatic state_e dispatch(input logic [5:0] opcode, input logic [5:0] funct);
    state_e tgt;
    tgt = StFetch;
    case (opcode)
      OpRtype: begin
        case (funct)
          FnAdd, FnSub, FnSlt: tgt = StExecR;
          FnJr:                tgt = StJr;
          default:             tgt = StFetch;
        endcase
      end
      OpAddi, OpXori: tgt = StExecI;
      OpLw, OpSw:     tgt = StMemAddr;
      OpBeq, OpBne:   tgt = StBranch;
      OpJ:            tgt = StJump;
      OpJal:          tgt = StJal;
      default:        tgt = StFetch;
    endcase
    return tgt;
  endfunction

endpackage

// File: rtl/mcpu_control_fsm_if.sv
// Control/status bundle between the control FSM and the datapath.
// master: the control FSM (consumes IR fields, zero, mem_ready; drives all controls).
// slave:  the datapath side.
interface mcpu_control_fsm_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_we;
  logic       ir_we;
  logic       a_we;
  logic       b_we;
  logic       ben;
  logic       mem_we;
  logic       reg_we;
  logic       memin;
  logic       dst;
  logic       regin;
  logic       jal;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [2:0] aluop;
  logic [1:0] pcsrc;
  logic [3:0] state;
  logic       retire;
  logic       illegal;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_we, ir_we, a_we, b_we, ben, mem_we, reg_we, memin, dst, regin, jal,
    output alusrca, alusrcb, aluop, pcsrc, state, retire, illegal
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_we, ir_we, a_we, b_we, ben, mem_we, reg_we, memin, dst, regin, jal,
    input  alusrca, alusrcb, aluop, pcsrc, state, retire, illegal
  );
endinterface

// File: rtl/mcpu_ctrl_decode.sv
// Combinational control-word decoder: current state plus IR fields, zero and
// mem_ready -> every datapath enable, select and ALU command.
// Ports:
//   state_i     current FSM state
//   opcode_i    IR[31:26]
//   funct_i     IR[5:0]
//   zero_i      ALU zero flag (used by BRANCH)
//   mem_ready_i memory strobe (gates FETCH writes and MEM_WR retire)
//   ctrl_o      full control word
module mcpu_ctrl_decode
  import mcpu_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  logic legal;
  assign legal = (dispatch(opcode_i, funct_i) != StFetch);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      StFetch: begin
        ctrl_o.memin   = 1'b0;
        ctrl_o.ir_we   = mem_ready_i;
        ctrl_o.pc_we   = mem_ready_i;
        ctrl_o.alusrca = SrcAPc;
        ctrl_o.alusrcb = SrcBFour;
        ctrl_o.aluop   = AluAdd;
        ctrl_o.pcsrc   = PcAlu;
      end
      StDecode: begin
        // Branch target PC + (imm << 2) is computed here and latched into BEN.
        ctrl_o.a_we    = legal;
        ctrl_o.b_we    = legal;
        ctrl_o.ben     = legal;
        ctrl_o.alusrca = SrcAPc;
        ctrl_o.alusrcb = SrcBImmSh;
        ctrl_o.aluop   = AluAdd;
        ctrl_o.illegal = ~legal;
      end
      StExecR: begin
        ctrl_o.alusrca = SrcAReg;
        ctrl_o.alusrcb = SrcBReg;
        case (funct_i)
          FnSub:   ctrl_o.aluop = AluSub;
          FnSlt:   ctrl_o.aluop = AluSlt;
          default: ctrl_o.aluop = AluAdd;
        endcase
      end
      StWbR: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.dst    = 1'b0;
        ctrl_o.regin  = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      StExecI: begin
        ctrl_o.alusrca = SrcAReg;
        ctrl_o.alusrcb = SrcBImm;
        ctrl_o.aluop   = (opcode_i == OpXori) ? AluXor : AluAdd;
      end
      StWbI: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.dst    = 1'b1;
        ctrl_o.regin  = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      StMemAddr: begin
        ctrl_o.alusrca = SrcAReg;
        ctrl_o.alusrcb = SrcBImm;
        ctrl_o.aluop   = AluAdd;
      end
      StMemRd: begin
        ctrl_o.memin = 1'b1;
      end
      StMemWb: begin
        ctrl_o.reg_we = 1'b1;
        ctrl_o.dst    = 1'b1;
        ctrl_o.regin  = 1'b0;
        ctrl_o.retire = 1'b1;
      end
      StMemWr: begin
        ctrl_o.memin  = 1'b1;
        ctrl_o.mem_we = 1'b1;
        ctrl_o.retire = mem_ready_i;
      end
      StBranch: begin
        ctrl_o.alusrca = SrcAReg;
        ctrl_o.alusrcb = SrcBReg;
        ctrl_o.aluop   = AluSub;
        ctrl_o.pcsrc   = PcBen;
        ctrl_o.pc_we   = (opcode_i == OpBne) ? ~zero_i : zero_i;
        ctrl_o.retire  = 1'b1;
      end
      StJump: begin
        ctrl_o.pcsrc  = PcJump;
        ctrl_o.pc_we  = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      StJal: begin
        ctrl_o.pcsrc  = PcJump;
        ctrl_o.pc_we  = 1'b1;
        ctrl_o.reg_we = 1'b1;
        ctrl_o.jal    = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      StJr: begin
        ctrl_o.pcsrc  = PcA;
        ctrl_o.pc_we  = 1'b1;
        ctrl_o.retire = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/mcpu_control_fsm.sv
// Multi-cycle control FSM for the single-memory MIPS-subset CPU.
// Holds the state register and next-state logic; control outputs come from
// mcpu_ctrl_decode.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low; forces FETCH and blocks FETCH writes while low
//   bus    mcpu_control_fsm_if.master: IR fields, zero, mem_ready in; controls out
module mcpu_control_fsm
  import mcpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  mcpu_control_fsm_if.master  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  mcpu_ctrl_decode u_decode (
    .state_i     (state_q),
    .opcode_i    (bus.opcode),
    .funct_i     (bus.funct),
    .zero_i      (bus.zero),
    .mem_ready_i (bus.mem_ready),
    .ctrl_o      (ctrl)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:   if (bus.mem_ready) state_d = StDecode;
      StDecode:  state_d = dispatch(bus.opcode, bus.funct);
      StExecR:   state_d = StWbR;
      StExecI:   state_d = StWbI;
      StMemAddr: state_d = (bus.opcode == OpLw) ? StMemRd : StMemWr;
      StMemRd:   if (bus.mem_ready) state_d = StMemWb;
      StMemWr:   if (bus.mem_ready) state_d = StFetch;
      StWbR, StWbI, StMemWb, StBranch, StJump, StJal, StJr: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // State is already FETCH during reset; only the mem_ready-driven writes need masking.
  assign bus.pc_we   = ctrl.pc_we & reset;
  assign bus.ir_we   = ctrl.ir_we & reset;
  assign bus.a_we    = ctrl.a_we;
  assign bus.b_we    = ctrl.b_we;
  assign bus.ben     = ctrl.ben;
  assign bus.mem_we  = ctrl.mem_we;
  assign bus.reg_we  = ctrl.reg_we;
  assign bus.memin   = ctrl.memin;
  assign bus.dst     = ctrl.dst;
  assign bus.regin   = ctrl.regin;
  assign bus.jal     = ctrl.jal;
  assign bus.alusrca = ctrl.alusrca;
  assign bus.alusrcb = ctrl.alusrcb;
  assign bus.aluop   = ctrl.aluop;
  assign bus.pcsrc   = ctrl.pcsrc;
  assign bus.retire  = ctrl.retire;
  assign bus.illegal = ctrl.illegal;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mcpu_control_fsm.sv
// Scoreboard bench for mcpu_control_fsm: the driver builds an expected per-instruction
// summary from the instruction rules, queues it, and plays a matching stimulus
// schedule; the monitor accumulates what the DUT does and compares on retire/illegal.
module tb_mcpu_control_fsm;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mcpu_control_fsm_if bus ();

  mcpu_control_fsm u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          cycles;
    logic [63:0] trace;
    int          n_pc_we;
    int          n_ir_we;
    int          n_ab;
    int          n_reg_we;
    int          n_mem_we;
    int          last_pcsrc;
    int          aluop;
    int          alusrcb;
    int          wb_dst;
    int          wb_regin;
    int          wb_jal;
    int          wb_pc_we;
    bit          illegal;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: expected state walk and per-instruction effects.
  function automatic exp_t model(input int op, input int fn, input int f, input int m,
                                 input bit z);
    exp_t e;
    int   st[$];
    e = '{cycles: 0, trace: 64'h0, n_pc_we: 1, n_ir_we: 1, n_ab: 3, n_reg_we: 0,
          n_mem_we: 0, last_pcsrc: 2, aluop: -1, alusrcb: -1, wb_dst: -1, wb_regin: -1,
          wb_jal: -1, wb_pc_we: -1, illegal: 1'b0};
    for (int i = 0; i <= f; i++) st.push_back(0);
    st.push_back(1);
    if (op == 'h00 && (fn == 'h20 || fn == 'h22 || fn == 'h2A)) begin
      st.push_back(2); st.push_back(3);
      e.aluop = (fn == 'h20) ? 0 : (fn == 'h22) ? 1 : 3;
      e.alusrcb = 2;
      e.n_reg_we = 1; e.wb_dst = 0; e.wb_regin = 1; e.wb_jal = 0; e.wb_pc_we = 0;
    end else if (op == 'h00 && fn == 'h08) begin
      st.push_back(13);
      e.n_pc_we = 2; e.last_pcsrc = 3;
    end else if (op == 'h08 || op == 'h0E) begin
      st.push_back(4); st.push_back(5);
      e.aluop = (op == 'h0E) ? 2 : 0;
      e.alusrcb = 1;
      e.n_reg_we = 1; e.wb_dst = 1; e.wb_regin = 1; e.wb_jal = 0; e.wb_pc_we = 0;
    end else if (op == 'h23) begin
      st.push_back(6);
      for (int i = 0; i <= m; i++) st.push_back(7);
      st.push_back(8);
      e.aluop = 0; e.alusrcb = 1;
      e.n_reg_we = 1; e.wb_dst = 1; e.wb_regin = 0; e.wb_jal = 0; e.wb_pc_we = 0;
    end else if (op == 'h2B) begin
      st.push_back(6);
      for (int i = 0; i <= m; i++) st.push_back(9);
      e.aluop = 0; e.alusrcb = 1;
      e.n_mem_we = m + 1;
    end else if (op == 'h04 || op == 'h05) begin
      st.push_back(10);
      e.aluop = 1; e.alusrcb = 2;
      if ((op == 'h04) == z) begin
        e.n_pc_we = 2; e.last_pcsrc = 0;
      end
    end else if (op == 'h02) begin
      st.push_back(11);
      e.n_pc_we = 2; e.last_pcsrc = 1;
    end else if (op == 'h03) begin
      st.push_back(12);
      e.n_pc_we = 2; e.last_pcsrc = 1;
      e.n_reg_we = 1; e.wb_dst = 0; e.wb_regin = 0; e.wb_jal = 1; e.wb_pc_we = 1;
    end else begin
      e.illegal = 1'b1; e.n_ab = 0;
    end
    e.cycles = st.size();
    foreach (st[i]) e.trace = {e.trace[59:0], 4'(st[i])};
    return e;
  endfunction

  // Queue the expectation, then play a schedule that honours f fetch stalls, m memory
  // stalls and the branch zero flag; don't-care cycles get random mem_ready/zero.
  task automatic run_instr(input int op, input int fn, input int f, input int m, input bit z);
    exp_t e;
    bit   is_mem;
    bit   is_br;
    e = model(op, fn, f, m, z);
    exp_q.push_back(e);
    is_mem = (op == 'h23 || op == 'h2B);
    is_br  = (op == 'h04 || op == 'h05);
    for (int c = 0; c < e.cycles; c++) begin
      bus.zero      = 1'($urandom_range(0, 1));
      bus.mem_ready = 1'($urandom_range(0, 1));
      if (c <= f) begin
        bus.opcode    = 6'($urandom);
        bus.funct     = 6'($urandom);
        bus.mem_ready = (c == f);
      end else begin
        bus.opcode = 6'(op);
        bus.funct  = 6'(fn);
      end
      if (is_mem && c >= f + 3) bus.mem_ready = (c == f + 3 + m);
      if (is_br && c == f + 2) bus.zero = z;
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor
  int          o_cycles, o_pc, o_ir, o_ab, o_reg, o_mem, o_pcsrc, o_aluop, o_srcb;
  int          o_dst, o_regin, o_jal, o_wbpc;
  logic [63:0] o_trace;

  task automatic clear_obs();
    o_cycles = 0; o_trace = 64'h0; o_pc = 0; o_ir = 0; o_ab = 0; o_reg = 0; o_mem = 0;
    o_pcsrc = -1; o_aluop = -1; o_srcb = -1; o_dst = -1; o_regin = -1; o_jal = -1;
    o_wbpc = -1;
  endtask

  initial begin
    exp_t e;
    clear_obs();
    forever begin
      @(negedge clk);
      if (!reset) begin
        clear_obs();
      end else if (mon_en) begin
        o_cycles++;
        o_trace = {o_trace[59:0], bus.state};
        o_pc  += int'(bus.pc_we);
        o_ir  += int'(bus.ir_we);
        o_ab  += int'(bus.a_we) + int'(bus.b_we) + int'(bus.ben);
        o_reg += int'(bus.reg_we);
        o_mem += int'(bus.mem_we);
        if (bus.pc_we) o_pcsrc = int'(bus.pcsrc);
        if (bus.alusrca == 2'd1 && o_aluop < 0) begin
          o_aluop = int'(bus.aluop);
          o_srcb  = int'(bus.alusrcb);
        end
        if (bus.reg_we) begin
          o_dst = int'(bus.dst); o_regin = int'(bus.regin);
          o_jal = int'(bus.jal); o_wbpc = int'(bus.pc_we);
        end
        if (bus.retire || bus.illegal) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_end: got retire=%0b illegal=%0b, required none",
                     bus.retire, bus.illegal);
          end else begin
            e = exp_q.pop_front();
            check("illegal", bus.illegal, e.illegal);
            check("retire", bus.retire, !e.illegal);
            check("cycles", o_cycles, e.cycles);
            check("state_trace", o_trace, e.trace);
            check("pc_we_count", o_pc, e.n_pc_we);
            check("ir_we_count", o_ir, e.n_ir_we);
            check("ab_ben_count", o_ab, e.n_ab);
            check("reg_we_count", o_reg, e.n_reg_we);
            check("mem_we_count", o_mem, e.n_mem_we);
            check("last_pcsrc", o_pcsrc, e.last_pcsrc);
            check("aluop", o_aluop, e.aluop);
            check("alusrcb", o_srcb, e.alusrcb);
            check("wb_dst", o_dst, e.wb_dst);
            check("wb_regin", o_regin, e.wb_regin);
            check("wb_jal", o_jal, e.wb_jal);
            check("wb_pc_we", o_wbpc, e.wb_pc_we);
          end
          clear_obs();
        end
      end
    end
  end

  task automatic drain(input string name);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    check(name, exp_q.size(), 0);
  endtask

  int tab_op[16] = '{'h00, 'h00, 'h00, 'h00, 'h08, 'h0E, 'h23, 'h2B,
                     'h04, 'h05, 'h02, 'h03, 'h3F, 'h01, 'h00, 'h00};
  int tab_fn[16] = '{'h20, 'h22, 'h2A, 'h08, 0, 0, 0, 0,
                     0, 0, 0, 0, 0, 0, 'h21, 'h00};

  initial begin
    reset         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", bus.state, 0);
    check("rst_pc_we", bus.pc_we, 0);
    check("rst_ir_we", bus.ir_we, 0);
    check("rst_retire", bus.retire, 0);
    check("rst_illegal", bus.illegal, 0);
    check("rst_alusrcb", bus.alusrcb, 3);
    check("rst_pcsrc", bus.pcsrc, 2);
    check("rst_mem_we", bus.mem_we, 0);
    @(posedge clk);
    #1;
    reset  = 1'b1;
    mon_en = 1'b1;

    // Directed cases
    run_instr('h00, 'h20, 0, 0, 1'b0);  // ADD
    run_instr('h23, 'h11, 0, 2, 1'b0);  // LW, two memory stalls
    run_instr('h04, 'h05, 0, 0, 1'b1);  // BEQ taken
    run_instr('h05, 'h05, 0, 0, 1'b1);  // BNE not taken
    run_instr('h03, 'h00, 1, 0, 1'b0);  // JAL
    run_instr('h00, 'h08, 0, 0, 1'b0);  // JR
    run_instr('h3F, 'h00, 0, 0, 1'b0);  // illegal opcode

    // Randomized stream
    for (int n = 0; n < 40; n++) begin
      int idx;
      int fn;
      idx = int'($urandom_range(0, 15));
      fn  = (tab_op[idx] == 'h00) ? tab_fn[idx] : int'($urandom_range(0, 63));
      run_instr(tab_op[idx], fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end
    drain("drain_random");

    // Reset while MEM_WR is stalled
    mon_en        = 1'b0;
    bus.opcode    = 6'h2B;
    bus.funct     = 6'h00;
    bus.mem_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("sw_stall_state", bus.state, 9);
    check("sw_stall_mem_we", bus.mem_we, 1);
    check("sw_stall_retire", bus.retire, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("sw_stall2_mem_we", bus.mem_we, 1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_mem_we", bus.mem_we, 0);
    check("abort_state", bus.state, 0);
    check("abort_retire", bus.retire, 0);
    bus.mem_ready = 1'b1;
    #1;
    check("abort_pc_we", bus.pc_we, 0);
    check("abort_ir_we", bus.ir_we, 0);
    check("abort_alusrcb", bus.alusrcb, 3);
    @(posedge clk);
    #1;
    check("hold_state", bus.state, 0);
    check("hold_retire", bus.retire, 0);
    reset  = 1'b1;
    mon_en = 1'b1;
    run_instr('h03, 'h00, 0, 0, 1'b0);  // JAL resumes from FETCH
    run_instr('h2B, 'h00, 0, 1, 1'b0);  // SW completes normally
    drain("drain_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
